// File: rtl/tmiv_gen.sv
// Time-interval event generator: buffers 5-bit interval words and reproduces each
// one as the spacing between evs rising edges. Optional edge counter: TMIV_GEN_STATS_EN.
module tmiv_gen #(
    parameter int AW = 3,
    parameter int PW = 2
) (
    input  logic        clk,
    input  logic        _rst,
    input  logic [4:0]  cnt,
    input  logic        cnt_st,
    output logic        full,
    output logic        err_st,
    output logic        evs,
    output logic        busy,
    output logic [15:0] edge_cnt
);

    localparam int             DEPTH     = 2**AW;
    localparam logic [AW:0]    DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [4:0]     MIN       = 5'(PW + 1);
    localparam logic [4:0]     HIGH_LAST = 5'(PW - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HIGH} state_t;

    logic [4:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    state_t        state_q, state_d;
    logic [4:0]    timer_q, timer_d;
    logic [4:0]    hcnt_q, hcnt_d;
    logic          last_q, last_d;
    logic          evs_q, evs_d;
    logic          full_q, err_q, busy_q;
    logic          wr_en, pop, empty;
    logic [4:0]    rd_word;

    assign empty   = (count_q == '0);
    assign rd_word = mem_q[rd_ptr_q];
    // full is the registered flag, so a pop in the same cycle cannot admit a write.
    assign wr_en   = cnt_st && !full_q && (cnt >= MIN);

    // NOTE: storage needs no reset; emptiness is tracked by the reset pointers and count.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= cnt;
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        state_d = state_q;
        timer_d = timer_q;
        hcnt_d  = hcnt_q;
        last_d  = last_q;
        evs_d   = evs_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                evs_d = 1'b0;
                if (!empty) begin
                    pop     = 1'b1;
                    timer_d = rd_word - 5'd1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                evs_d = 1'b0;
                if (timer_q == '0) begin
                    evs_d   = 1'b1;
                    hcnt_d  = HIGH_LAST;
                    state_d = S_HIGH;
                    last_d  = empty;
                    // Prefetch at the rise so the next interval is timed from this edge.
                    if (!empty) begin
                        pop     = 1'b1;
                        timer_d = rd_word - 5'd1;
                    end
                end else begin
                    timer_d = timer_q - 5'd1;
                end
            end
            S_HIGH: begin
                if (timer_q != '0) timer_d = timer_q - 5'd1;
                if (hcnt_q == '0) begin
                    evs_d   = 1'b0;
                    state_d = last_q ? S_IDLE : S_WAIT;
                end else begin
                    hcnt_d = hcnt_q - 5'd1;
                end
            end
            default: begin
                evs_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (wr_en && !pop)      count_d = count_q + (AW+1)'(1);
        else if (!wr_en && pop) count_d = count_q - (AW+1)'(1);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            hcnt_q   <= '0;
            last_q   <= 1'b0;
            evs_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            hcnt_q   <= hcnt_d;
            last_q   <= last_d;
            evs_q    <= evs_d;
            count_q  <= count_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
            full_q   <= (count_d == DEPTH_C);
            err_q    <= cnt_st && (full_q || (cnt < MIN));
            busy_q   <= (state_d != S_IDLE) || (count_d != '0);
        end
    end

`ifdef TMIV_GEN_STATS_EN
    logic [15:0] edge_cnt_q;
    logic        rise;

    assign rise = (state_q == S_WAIT) && (timer_q == '0);

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst)     edge_cnt_q <= '0;
        else if (rise) edge_cnt_q <= edge_cnt_q + 16'd1;
    end

    assign edge_cnt = edge_cnt_q;
`else
    assign edge_cnt = '0;
`endif

    assign full   = full_q;
    assign err_st = err_q;
    assign evs    = evs_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_tmiv_gen.sv
// Self-checking bench for tmiv_gen: expected evs rise cycles are queued when words
// are written and compared as the rises appear.
module tb_tmiv_gen;

    localparam int PW = 2;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic [4:0]  cnt    = '0;
    logic        cnt_st = 1'b0;
    logic        full, err_st, evs, busy;
    logic [15:0] edge_cnt;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int exp_q[$];

    tmiv_gen #(.AW(3), .PW(PW)) dut (
        .clk      (clk),
        ._rst     (rst_n),
        .cnt      (cnt),
        .cnt_st   (cnt_st),
        .full     (full),
        .err_st   (err_st),
        .evs      (evs),
        .busy     (busy),
        .edge_cnt (edge_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Called at a negedge; returns the index of the posedge that sampled the write.
    task automatic drive_write(input logic [4:0] v, output int w);
        cnt    = v;
        cnt_st = 1'b1;
        @(negedge clk);
        w      = cyc;
        cnt_st = 1'b0;
    endtask

    task automatic wait_rise(input int budget, output int at);
        logic prev;
        prev = evs;
        at   = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (evs === 1'b1 && prev === 1'b0) begin
                at = cyc;
                break;
            end
            prev = evs;
        end
    endtask

    task automatic drain_rises(input int budget);
        int exp_c, at;
        while (exp_q.size() > 0) begin
            exp_c = exp_q.pop_front();
            wait_rise(budget, at);
            checks++;
            if (at !== exp_c) begin
                errors++;
                $display("FAIL rise_time: got cycle %0d, expected %0d", at, exp_c);
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({evs, full, err_st, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: evs/full/err/busy=%b, expected 0000", {evs, full, err_st, busy});
        end
        checks++;
        if (edge_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_edge_cnt: got %0d, expected 0", edge_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        int w;
        drive_write(5'd10, w);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy: got %b, expected 1", busy);
        end
        exp_q.push_back(w + 1 + 10);
        drain_rises(40);
        @(negedge clk);
        checks++;
        if (evs !== 1'b1) begin
            errors++;
            $display("FAIL single_high_width: evs=%b one cycle after rise, expected 1", evs);
        end
        @(negedge clk);
        checks++;
        if ({evs, busy} !== 2'b00) begin
            errors++;
            $display("FAIL single_end: evs/busy=%b after %0d high cycles, expected 00", {evs, busy}, PW);
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0] words [4] = '{5'd5, 5'd7, 5'd31, 5'd3};
        int w, r;
        for (int i = 0; i < 4; i++) begin
            drive_write(words[i], w);
            r = (i == 0) ? (w + 1 + int'(words[i])) : (r + int'(words[i]));
            exp_q.push_back(r);
            checks++;
            if (err_st !== 1'b0) begin
                errors++;
                $display("FAIL b2b_err: word %0d got err_st=%b, expected 0", i, err_st);
            end
        end
        drain_rises(50);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_bad_word;
        logic [4:0] bad [2] = '{5'd2, 5'd0};
        int w, at;
        for (int i = 0; i < 2; i++) begin
            drive_write(bad[i], w);
            checks++;
            if ({err_st, busy} !== 2'b10) begin
                errors++;
                $display("FAIL bad_err: cnt=%0d err/busy=%b, expected 10", bad[i], {err_st, busy});
            end
            @(negedge clk);
            checks++;
            if (err_st !== 1'b0) begin
                errors++;
                $display("FAIL bad_err_pulse: err_st=%b second cycle, expected 0", err_st);
            end
        end
        wait_rise(20, at);
        checks++;
        if (at !== -1) begin
            errors++;
            $display("FAIL bad_no_edge: rise at cycle %0d, expected none", at);
        end
    endtask

    task automatic test_full;
        int w, r, exp_c;
        drive_write(5'd31, w);
        r = w + 1 + 31;
        exp_q.push_back(r);
        for (int i = 0; i < 8; i++) begin
            drive_write(5'(20 + i), w);
            exp_q.push_back(exp_q[exp_q.size() - 1] + 20 + i);
            checks++;
            if (full !== (i == 7)) begin
                errors++;
                $display("FAIL full_flag: after word %0d full=%b, expected %b", i, full, (i == 7));
            end
        end
        drive_write(5'd25, w);
        checks++;
        if ({err_st, full} !== 2'b11) begin
            errors++;
            $display("FAIL full_reject: err/full=%b, expected 11", {err_st, full});
        end
        while (cyc < r - 1) @(negedge clk);
        // Write lands on the edge that pops the head: still rejected.
        drive_write(5'd9, w);
        checks++;
        if ({err_st, full} !== 2'b10) begin
            errors++;
            $display("FAIL full_pop_write: err/full=%b at cycle %0d, expected 10", {err_st, full}, w);
        end
        exp_c = exp_q.pop_front();
        checks++;
        if (!(evs === 1'b1 && cyc == exp_c)) begin
            errors++;
            $display("FAIL full_first_rise: evs=%b at cycle %0d, expected 1 at %0d", evs, cyc, exp_c);
        end
        drain_rises(40);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_underrun;
        int w, r;
        drive_write(5'd4, w);
        exp_q.push_back(w + 1 + 4);
        drain_rises(20);
        r = cyc;
        drive_write(5'd6, w);
        exp_q.push_back(r + PW + 1 + 6);
        drain_rises(30);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int w, at;
        drive_write(5'd10, w);
        exp_q.push_back(w + 1 + 10);
        drive_write(5'd8, at);
        drive_write(5'd8, at);
        drain_rises(30);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({evs, busy, full, err_st} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid: evs/busy/full/err=%b, expected 0000", {evs, busy, full, err_st});
        end
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (edge_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_edge_cnt: got %0d, expected 0", edge_cnt);
        end
        wait_rise(40, at);
        checks++;
        if (at !== -1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard: rise at %0d busy=%b, expected none and 0", at, busy);
        end
        drive_write(5'd5, w);
        exp_q.push_back(w + 6);
        drive_write(5'd5, w);
        exp_q.push_back(exp_q[0] + 5);
        drive_write(5'd5, w);
        exp_q.push_back(exp_q[1] + 5);
        drain_rises(30);
        checks++;
`ifdef TMIV_GEN_STATS_EN
        if (edge_cnt !== 16'd3) begin
            errors++;
            $display("FAIL edge_count: got %0d, expected 3", edge_cnt);
        end
`else
        if (edge_cnt !== 16'd0) begin
            errors++;
            $display("FAIL edge_count_off: got %0d, expected 0", edge_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_bad_word();
        test_full();
        test_underrun();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tmiv_gen.md
Name: tmiv_gen

Overview:
- Time-interval event generator; the transmit-side counterpart of the event-interval counter.
- Accepts a stream of 5-bit interval words and buffers them in a small FIFO.
- Reproduces each interval as the spacing between rising edges on a single event line `evs`.
- Used for loopback/self-test of the interval-measurement path and for driving synthetic spike trains onto an event link.

Parameters:
- AW, 3: FIFO address width; depth = 2**AW words.
- PW, 2: evs high time in clk cycles; legal range 1..29.
- MIN: derived constant, MIN = PW+1. Smallest accepted interval word.

Ports:
- clk  in  1  single clock, posedge.
- _rst  in  1  asynchronous active-low reset.
- cnt  in  5  interval word, in clk cycles between successive evs rising edges.
- cnt_st  in  1  write strobe for cnt; one word per cycle.
- full  out  1  FIFO full.
- err_st  out  1  one-cycle error pulse.
- evs  out  1  generated event line, registered.
- busy  out  1  FSM not in IDLE, or FIFO non-empty.
- edge_cnt  out  16  count of emitted edges (optional feature only).

Behaviour:
- Reset (async, _rst=0): FIFO empty, FSM=IDLE, timer=0; outputs evs=0, full=0, err_st=0, busy=0, edge_cnt=0.

Write side:
- Word accepted at a posedge when cnt_st=1, full=0 and cnt>=MIN.
- Write with full=1 or cnt<MIN: word dropped, FIFO unchanged, err_st=1 in the next cycle.
- full is registered. It rises in the cycle after the write that fills the last slot.
- Simultaneous write and pop when full: the pop frees a slot, but that write is still rejected because full=1 at the sampling edge.

Timer:
- 5-bit down-counter, loaded from the popped word.
- Decrements once per cycle; never wraps.

FSM states:
- IDLE: evs=0. If FIFO non-empty: pop, load timer=cnt-1, go WAIT. The pop cycle is the time reference for the first edge.
- WAIT: evs=0. When timer==0: drive evs=1 at the next edge (rise cycle R), go HIGH.
- HIGH: entered at R; evs stays 1 for PW cycles.
  - At R, the next word is popped (prefetch) if the FIFO is non-empty, and the timer is loaded with cnt-1.
  - If the FIFO is empty at R, set flag `last`.
  - After PW cycles: evs=0; go WAIT if a word was prefetched, else IDLE.
  - The prefetched timer keeps decrementing during HIGH.
- Word at R may be less than the remaining HIGH time: impossible, because cnt>=MIN guarantees at least one low cycle between pulses.
- Timing: rising edges of evs are exactly cnt_k clk cycles apart for back-to-back words.
- First edge after IDLE rises cnt cycles after the pop cycle.
- Write-to-edge latency from IDLE: write at edge W, pop at W+1, evs rises at W+1+cnt.
- Underrun: word written after R but before the PW cycles elapse is not prefetched. FSM returns to IDLE, and that word is timed from its own pop (no error).
- cnt=31 is a legal interval of 31 cycles; there is no saturation code on the transmit side.
- busy = (state!=IDLE) | ~empty, registered.
- Reset mid-pulse: evs goes to 0 asynchronously; the buffered words are discarded.

Optional Feature:
- Macro TMIV_GEN_STATS_EN.
- Defined: edge_cnt increments by 1 on every evs rising edge and wraps 16'hFFFF->0.
- Undefined: edge_cnt tied to 0 and the counter is not built.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then write cnt=10 once -> evs rises exactly 11 cycles after the write edge, high 2 cycles, then busy=0.
- Write 5, 7, 31, 3 back-to-back -> evs rising edges spaced 7, 31, 3 cycles after the first edge; no err_st.
- Write cnt=2 (PW=2) -> err_st pulses once, FIFO unchanged, evs stays 0.
- Fill the FIFO (8 words of 20) without draining, then write a 9th -> full=1 after the 8th, err_st on the 9th; all 8 intervals emitted in order.
- Write 4, wait for its edge, write 6 one cycle after the rise -> underrun path: IDLE, then evs rises 6 cycles after the pop.
- Assert _rst during HIGH -> evs=0 immediately and busy=0; with TMIV_GEN_STATS_EN, edge_cnt reads 0 after reset and counts 3 after three subsequent edges.
